alu_issue_ctrl: RTL and testbench

Issue-side controller for the adiabatic ALU. It accepts one operation at a time over a valid/ready request port and decodes the opcode into the ALU mux and control lines. It launches the operands in step with the Bennett clock generator's `instFlag` and pulses the `A_Fclkpos`/`ALU_O_Fclkpos` latch strobes at the full-charge plateau. It then samples `alu_out`/`out_Zero_Detect` and returns the result over a valid/ready response port.

---
 rtl/alu_issue_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue-side controller for the adiabatic ALU.
// Accepts one operation at a time, launches its operands and decoded controls
// on the rising edge of the Bennett instFlag, strobes the operand/result
// latches at the first full-charge plateau, samples the ALU result a fixed
// number of cycles later and returns it over a valid/ready response port.
// The ALU-facing operand and control registers only ever change at a launch,
// because the reversible discharge phase needs those inputs to stay put.

module alu_issue_ctrl #(
    parameter int WIDTH      = 16,
    parameter int CLK_W      = 13,
    parameter int SAMPLE_DLY = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             instFlag,
    input  logic [CLK_W-1:0] clkpos,
    input  logic [CLK_W-1:0] clkneg,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [WIDTH-1:0] req_pc,
    input  logic [WIDTH-1:0] req_instr,

    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] PC_in,
    output logic [WIDTH-1:0] instr_in,
    output logic             ALU_Control0,
    output logic             ALU_Control1,
    output logic             A_mux,
    output logic             Adder_Cin,
    output logic             B_mux0,
    output logic             B_mux1,
    output logic             SUB,
    output logic             STL,
    output logic             mux3_0,
    output logic             mux3_1,

    output logic             A_Fclkpos,
    output logic             ALU_O_Fclkpos,

    input  logic [WIDTH-1:0] alu_out,
    input  logic             out_Zero_Detect,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam int         TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        COMPUTE,
        SAMPLE,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             inst_q;
    logic             launch;
    logic             plateau;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] instr_q;

    logic [9:0]       ctrl_q;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       dly_cnt;

    logic             accept;
    logic             drive_alu;
    logic             strobe_set;
    logic             capture;
    logic             err_set;
    logic             to_inc;
    logic             dly_inc;

    // Control bit order: {C1, C0, A_mux, Adder_Cin, B_mux1, B_mux0, SUB, STL, mux3_1, mux3_0}
    function automatic logic [9:0] decode_op(input logic [2:0] op);
        logic [9:0] c;
        c = '0;
        case (op)
            3'd0:    c = 10'b10_1_0_11_0_0_00;  // ADD
            3'd1:    c = 10'b10_1_1_11_1_0_00;  // SUB
            3'd2:    c = 10'b00_1_0_11_0_0_00;  // AND
            3'd3:    c = 10'b01_1_0_11_0_0_00;  // OR
            3'd4:    c = 10'b10_1_1_11_1_1_00;  // SLT
            3'd5:    c = 10'b10_0_0_01_0_0_00;  // PCADD: PC + instr
            3'd6:    c = 10'b11_0_0_11_0_0_00;  // PASS_B
            default: c = '0;                    // reserved
        endcase
        return c;
    endfunction

    assign launch  = instFlag & ~inst_q;
    assign plateau = (&clkpos) & ~(|clkneg);

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    assign {ALU_Control1, ALU_Control0, A_mux, Adder_Cin, B_mux1, B_mux0,
            SUB, STL, mux3_1, mux3_0} = ctrl_q;

    // State register plus the instFlag delay used for launch-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            inst_q <= 1'b0;
        end else begin
            state  <= state_next;
            inst_q <= instFlag;
        end
    end

    // Next-state logic and the one-cycle action enables for the datapath
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drive_alu  = 1'b0;
        strobe_set = 1'b0;
        capture    = 1'b0;
        err_set    = 1'b0;
        to_inc     = 1'b0;
        dly_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (launch) begin
                    if (op_q == OP_RSVD) begin
                        err_set    = 1'b1;
                        state_next = RESP;
                    end else begin
                        drive_alu  = 1'b1;
                        state_next = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                if (plateau) begin
                    strobe_set = 1'b1;
                    state_next = SAMPLE;
                end else if (launch || (to_cnt == TO_W'(TIMEOUT))) begin
                    err_set    = 1'b1;
                    state_next = RESP;
                end else begin
                    to_inc = 1'b1;
                end
            end
            SAMPLE: begin
                if (dly_cnt == 4'(SAMPLE_DLY)) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else begin
                    dly_inc = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request holding registers, loaded only when a request is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (accept) begin
            op_q    <= req_op;
            a_q     <= req_a;
            b_q     <= req_b;
            pc_q    <= req_pc;
            instr_q <= req_instr;
        end
    end

    // ALU operands and controls, updated solely at a valid launch edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a        <= '0;
            b        <= '0;
            PC_in    <= '0;
            instr_in <= '0;
            ctrl_q   <= '0;
        end else if (drive_alu) begin
            a        <= a_q;
            b        <= b_q;
            PC_in    <= pc_q;
            instr_in <= instr_q;
            ctrl_q   <= decode_op(op_q);
        end
    end

    // Launch-to-plateau timeout and strobe-to-sample delay counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt  <= '0;
            dly_cnt <= '0;
        end else begin
            if (drive_alu) begin
                to_cnt <= TO_W'(1);
            end else if (to_inc) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (strobe_set) begin
                dly_cnt <= 4'd1;
            end else if (dly_inc) begin
                dly_cnt <= dly_cnt + 4'd1;
            end
        end
    end

    // Latch strobes: a single registered pulse per operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            A_Fclkpos     <= 1'b0;
            ALU_O_Fclkpos <= 1'b0;
        end else begin
            A_Fclkpos     <= strobe_set;
            ALU_O_Fclkpos <= strobe_set;
        end
    end

    // Response payload, written once per operation and held until the next
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (capture) begin
            rsp_data <= alu_out;
            rsp_zero <= out_Zero_Detect;
            rsp_err  <= 1'b0;
        end else if (err_set) begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl. Each task drives one scenario and
// compares DUT outputs against hand-computed values.

module tb_alu_issue_ctrl;

    localparam logic [9:0] C_ADD   = 10'b1010110000;
    localparam logic [9:0] C_SUB   = 10'b1011111000;
    localparam logic [9:0] C_OR    = 10'b0110110000;
    localparam logic [9:0] C_PASSB = 10'b1100110000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instFlag = 1'b0;
    logic [12:0] clkpos = '0;
    logic [12:0] clkneg = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [15:0] req_a = '0, req_b = '0, req_pc = '0, req_instr = '0;
    logic [15:0] a, b, PC_in, instr_in;
    logic        ALU_Control0, ALU_Control1, A_mux, Adder_Cin, B_mux0, B_mux1;
    logic        SUB, STL, mux3_0, mux3_1;
    logic        A_Fclkpos, ALU_O_Fclkpos;
    logic [15:0] alu_out = '0;
    logic        out_Zero_Detect = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_zero, rsp_err;

    logic [9:0]  ctrl;
    logic [63:0] ops;
    logic [1:0]  strobes;

    int total = 0;
    int bad = 0;

    assign ctrl    = {ALU_Control1, ALU_Control0, A_mux, Adder_Cin, B_mux1, B_mux0,
                      SUB, STL, mux3_1, mux3_0};
    assign ops     = {a, b, PC_in, instr_in};
    assign strobes = {A_Fclkpos, ALU_O_Fclkpos};

    alu_issue_ctrl #(
        .WIDTH(16), .CLK_W(13), .SAMPLE_DLY(2), .TIMEOUT(10)
    ) dut (
        .clk(clk), .reset(reset), .instFlag(instFlag), .clkpos(clkpos), .clkneg(clkneg),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_pc(req_pc), .req_instr(req_instr),
        .a(a), .b(b), .PC_in(PC_in), .instr_in(instr_in),
        .ALU_Control0(ALU_Control0), .ALU_Control1(ALU_Control1), .A_mux(A_mux),
        .Adder_Cin(Adder_Cin), .B_mux0(B_mux0), .B_mux1(B_mux1), .SUB(SUB), .STL(STL),
        .mux3_0(mux3_0), .mux3_1(mux3_1),
        .A_Fclkpos(A_Fclkpos), .ALU_O_Fclkpos(ALU_O_Fclkpos),
        .alu_out(alu_out), .out_Zero_Detect(out_Zero_Detect),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_plateau(input logic on);
        clkpos = on ? 13'h1FFF : 13'h0000;
        clkneg = 13'h0000;
    endtask

    task automatic send_req(input logic [2:0] op, input logic [15:0] ra, input logic [15:0] rb,
                            input logic [15:0] rpc, input logic [15:0] rin);
        req_op = op; req_a = ra; req_b = rb; req_pc = rpc; req_instr = rin;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic launch();
        instFlag = 1'b0;
        tick();
        instFlag = 1'b1;
        tick();
    endtask

    task automatic run_to_resp();
        set_plateau(1'b1);
        tick();
        set_plateau(1'b0);
        tick();
        tick();
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick(); tick();
        total++; if (ops !== 64'd0) begin bad++; $display("FAIL reset_ops got=%h want=0", ops); end
        total++; if (ctrl !== 10'd0) begin bad++; $display("FAIL reset_ctrl got=%b want=0", ctrl); end
        total++; if (strobes !== 2'b00) begin bad++; $display("FAIL reset_strobe got=%b want=00", strobes); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if ({rsp_data, rsp_zero, rsp_err} !== 18'd0) begin bad++; $display("FAIL reset_payload got=%h want=0", {rsp_data, rsp_zero, rsp_err}); end
        reset = 1'b1;
        tick();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_add();
        alu_out = 16'h0003; out_Zero_Detect = 1'b0; rsp_ready = 1'b0;
        send_req(3'd0, 16'd1, 16'd2, 16'h0100, 16'h0010);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL add_req_ready got=%b want=0", req_ready); end
        tick();
        total++; if (ops !== 64'd0) begin bad++; $display("FAIL add_prelaunch_ops got=%h want=0", ops); end
        instFlag = 1'b1;
        tick();
        total++; if (ops !== {16'd1, 16'd2, 16'h0100, 16'h0010}) begin bad++; $display("FAIL add_ops got=%h", ops); end
        total++; if (ctrl !== C_ADD) begin bad++; $display("FAIL add_ctrl got=%b want=%b", ctrl, C_ADD); end
        tick(); tick();
        total++; if (strobes !== 2'b00) begin bad++; $display("FAIL add_early_strobe got=%b want=00", strobes); end
        set_plateau(1'b1);
        tick();
        total++; if (strobes !== 2'b11) begin bad++; $display("FAIL add_strobe got=%b want=11", strobes); end
        tick();
        total++; if (strobes !== 2'b00) begin bad++; $display("FAIL add_strobe_width got=%b want=00", strobes); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add_rsp_early got=%b want=0", rsp_valid); end
        tick();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL add_latency got=%b want=1", rsp_valid); end
        total++; if ({rsp_data, rsp_zero, rsp_err} !== {16'h0003, 1'b0, 1'b0}) begin bad++; $display("FAIL add_payload got=%h/%b/%b want=0003/0/0", rsp_data, rsp_zero, rsp_err); end
        set_plateau(1'b0); instFlag = 1'b0;
        ack();
        total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL add_done got=%b want=01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_sub_zero();
        alu_out = 16'h0000; out_Zero_Detect = 1'b1; rsp_ready = 1'b1;
        instFlag = 1'b1;
        send_req(3'd1, 16'h0005, 16'h0005, 16'h0200, 16'h0020);
        tick(); tick();
        total++; if (ops !== {16'd1, 16'd2, 16'h0100, 16'h0010}) begin bad++; $display("FAIL same_cycle_launch_ops got=%h", ops); end
        total++; if (ctrl !== C_ADD) begin bad++; $display("FAIL same_cycle_launch_ctrl got=%b want=%b", ctrl, C_ADD); end
        launch();
        total++; if (ops !== {16'h0005, 16'h0005, 16'h0200, 16'h0020}) begin bad++; $display("FAIL sub_ops got=%h", ops); end
        total++; if (ctrl !== C_SUB) begin bad++; $display("FAIL sub_ctrl got=%b want=%b", ctrl, C_SUB); end
        set_plateau(1'b1);
        tick();
        total++; if (strobes !== 2'b11) begin bad++; $display("FAIL sub_strobe got=%b want=11", strobes); end
        set_plateau(1'b0);
        tick(); tick();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL sub_latency got=%b want=1", rsp_valid); end
        total++; if ({rsp_data, rsp_zero, rsp_err} !== {16'h0000, 1'b1, 1'b0}) begin bad++; $display("FAIL sub_payload got=%h/%b/%b want=0000/1/0", rsp_data, rsp_zero, rsp_err); end
        tick();
        total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL sub_fast_ack got=%b want=01", {rsp_valid, req_ready}); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        alu_out = 16'h0FFF; out_Zero_Detect = 1'b0; rsp_ready = 1'b0;
        send_req(3'd3, 16'h00F0, 16'h0F0F, 16'h0300, 16'h0030);
        launch();
        run_to_resp();
        for (int i = 0; i < 20; i++) begin
            req_valid = 1'b1; req_op = 3'd2; req_a = 16'hDEAD; req_b = 16'hBEEF;
            instFlag = (i < 3 || i >= 6);
            set_plateau(i == 8);
            alu_out = 16'h7777;
            tick();
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, rsp_valid); end
            total++; if ({rsp_data, rsp_zero, rsp_err} !== {16'h0FFF, 1'b0, 1'b0}) begin bad++; $display("FAIL bp_payload[%0d] got=%h/%b/%b want=0fff/0/0", i, rsp_data, rsp_zero, rsp_err); end
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready[%0d] got=%b want=0", i, req_ready); end
            total++; if (ops !== {16'h00F0, 16'h0F0F, 16'h0300, 16'h0030}) begin bad++; $display("FAIL bp_ops[%0d] got=%h", i, ops); end
            total++; if (ctrl !== C_OR) begin bad++; $display("FAIL bp_ctrl[%0d] got=%b want=%b", i, ctrl, C_OR); end
            total++; if (strobes !== 2'b00) begin bad++; $display("FAIL bp_strobe[%0d] got=%b want=00", i, strobes); end
        end
        req_valid = 1'b0; set_plateau(1'b0);
        ack();
        total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL bp_release got=%b want=01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_decode();
        logic [2:0] op_t [4];
        logic [9:0] exp_t [4];
        op_t  = '{3'd2, 3'd4, 3'd5, 3'd6};
        exp_t = '{10'b0010110000, 10'b1011111100, 10'b1000010000, 10'b1100110000};
        for (int i = 0; i < 4; i++) begin
            alu_out = 16'h1000 + 16'(i); out_Zero_Detect = 1'b0;
            send_req(op_t[i], 16'h0010 + 16'(i), 16'h0020 + 16'(i), 16'h0400 + 16'(i), 16'h0040 + 16'(i));
            launch();
            total++; if (ctrl !== exp_t[i]) begin bad++; $display("FAIL decode_ctrl op=%0d got=%b want=%b", op_t[i], ctrl, exp_t[i]); end
            total++; if (ops !== {16'h0010 + 16'(i), 16'h0020 + 16'(i), 16'h0400 + 16'(i), 16'h0040 + 16'(i)}) begin bad++; $display("FAIL decode_ops op=%0d got=%h", op_t[i], ops); end
            run_to_resp();
            total++; if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 16'h1000 + 16'(i), 1'b0}) begin bad++; $display("FAIL decode_rsp op=%0d got=%b/%h/%b", op_t[i], rsp_valid, rsp_data, rsp_err); end
            ack();
        end
    endtask

    task automatic test_reserved();
        alu_out = 16'h4242;
        send_req(3'd7, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rsvd_early got=%b want=0", rsp_valid); end
        launch();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rsvd_valid got=%b want=1", rsp_valid); end
        total++; if ({rsp_data, rsp_err} !== {16'h0000, 1'b1}) begin bad++; $display("FAIL rsvd_payload got=%h/%b want=0000/1", rsp_data, rsp_err); end
        total++; if (ops !== {16'h0013, 16'h0023, 16'h0403, 16'h0043}) begin bad++; $display("FAIL rsvd_ops_held got=%h", ops); end
        total++; if (ctrl !== C_PASSB) begin bad++; $display("FAIL rsvd_ctrl_held got=%b want=%b", ctrl, C_PASSB); end
        total++; if (strobes !== 2'b00) begin bad++; $display("FAIL rsvd_strobe got=%b want=00", strobes); end
        ack();
    endtask

    task automatic test_timeout();
        alu_out = 16'hBEEF; out_Zero_Detect = 1'b1;
        send_req(3'd0, 16'd7, 16'd8, 16'h0500, 16'h0050);
        launch();
        total++; if (ops !== {16'd7, 16'd8, 16'h0500, 16'h0050}) begin bad++; $display("FAIL to_ops got=%h", ops); end
        for (int k = 1; k <= 9; k++) begin
            tick();
            total++; if ({rsp_valid, strobes} !== 3'b000) begin bad++; $display("FAIL to_wait[%0d] got=%b want=000", k, {rsp_valid, strobes}); end
        end
        tick();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL to_valid got=%b want=1", rsp_valid); end
        total++; if ({rsp_data, rsp_zero, rsp_err} !== {16'h0000, 1'b0, 1'b1}) begin bad++; $display("FAIL to_payload got=%h/%b/%b want=0000/0/1", rsp_data, rsp_zero, rsp_err); end
        total++; if (strobes !== 2'b00) begin bad++; $display("FAIL to_strobe got=%b want=00", strobes); end
        ack();
    endtask

    task automatic test_relaunch();
        alu_out = 16'h5A5A; out_Zero_Detect = 1'b0;
        send_req(3'd1, 16'd9, 16'd10, 16'h0600, 16'h0060);
        launch();
        instFlag = 1'b0;
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL relaunch_early got=%b want=0", rsp_valid); end
        instFlag = 1'b1;
        tick();
        total++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 16'h0000}) begin bad++; $display("FAIL relaunch_err got=%b/%b/%h want=1/1/0000", rsp_valid, rsp_err, rsp_data); end
        total++; if (strobes !== 2'b00) begin bad++; $display("FAIL relaunch_strobe got=%b want=00", strobes); end
        ack();
    endtask

    task automatic test_reset_mid();
        alu_out = 16'h5555; out_Zero_Detect = 1'b0;
        send_req(3'd0, 16'h1234, 16'h1111, 16'h0700, 16'h0070);
        launch();
        set_plateau(1'b1);
        tick();
        total++; if (strobes !== 2'b11) begin bad++; $display("FAIL rmid_strobe got=%b want=11", strobes); end
        #1 reset = 1'b0;
        #1;
        total++; if (ops !== 64'd0) begin bad++; $display("FAIL rmid_ops got=%h want=0", ops); end
        total++; if (ctrl !== 10'd0) begin bad++; $display("FAIL rmid_ctrl got=%b want=0", ctrl); end
        total++; if (strobes !== 2'b00) begin bad++; $display("FAIL rmid_strobe_clr got=%b want=00", strobes); end
        total++; if ({rsp_valid, rsp_data, rsp_zero, rsp_err} !== 19'd0) begin bad++; $display("FAIL rmid_rsp got=%h want=0", {rsp_valid, rsp_data, rsp_zero, rsp_err}); end
        set_plateau(1'b0);
        tick(); tick();
        reset = 1'b1;
        tick();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_req_ready got=%b want=1", req_ready); end
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale[%0d] got=%b want=0", k, rsp_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_zero();
        test_backpressure();
        test_decode();
        test_reserved();
        test_timeout();
        test_relaunch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
